// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, column drive patterns and key encoding for the keypad scanner
package keypad_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_PEND, HELD, REL_PEND} db_state_e;
  localparam logic [3:0][3:0] COL_PATTERN = {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  localparam logic [4:0] NO_KEY = 5'h10;
  function automatic logic [4:0] key_code_f(input logic [1:0] r, input logic [1:0] c);
    return {1'b0, r, c};
  endfunction
endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: per-sweep debounce FSM that accepts presses and tracks key hold/release
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       sweep_i,
  input  logic [4:0] result_i,
  output logic [3:0] key_code_o,
  output logic       key_valid_o,
  output logic       key_down_o
);
  localparam bit SINGLE = (DEBOUNCE == 1);
  localparam logic [3:0] DB = 4'(DEBOUNCE);
  db_state_e state_q, state_d;
  logic [3:0] cand_q, cand_d, cnt_q, cnt_d, code_q, code_d, key, cnt_inc;
  logic valid_q, valid_d, down_q, down_d, no_key, reached, accept;
  assign key = result_i[3:0];
  assign no_key = result_i[4];
  assign cnt_inc = (cnt_q == 4'hF) ? cnt_q : cnt_q + 4'd1;
  assign reached = cnt_inc >= DB;
  always_comb begin
    state_d = state_q;
    cand_d = cand_q;
    cnt_d = cnt_q;
    code_d = code_q;
    valid_d = 1'b0;
    down_d = down_q;
    accept = 1'b0;
    if (sweep_i) begin
      case (state_q)
        IDLE: if (!no_key) begin
          cand_d = key;
          cnt_d = 4'd1;
          state_d = SINGLE ? HELD : PRESS_PEND;
          accept = SINGLE;
        end
        PRESS_PEND: if (no_key) begin
          state_d = IDLE;
          cnt_d = 4'd0;
        end else if (key != cand_q) begin
          cand_d = key;
          cnt_d = 4'd1;
        end else begin
          cnt_d = cnt_inc;
          state_d = reached ? HELD : PRESS_PEND;
          accept = reached;
        end
        HELD: if (no_key) begin
          cnt_d = SINGLE ? 4'd0 : 4'd1;
          state_d = SINGLE ? IDLE : REL_PEND;
          down_d = !SINGLE;
        end
        REL_PEND: if (!no_key) begin
          state_d = HELD;
          cnt_d = 4'd0;
        end else begin
          cnt_d = cnt_inc;
          state_d = reached ? IDLE : REL_PEND;
          down_d = !reached;
        end
        default: state_d = IDLE;
      endcase
    end
    if (accept) begin
      code_d = key;
      valid_d = 1'b1;
      down_d = 1'b1;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cand_q <= 4'd0;
      cnt_q <= 4'd0;
      code_q <= 4'd0;
      valid_q <= 1'b0;
      down_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q <= cand_d;
      cnt_q <= cnt_d;
      code_q <= code_d;
      valid_q <= valid_d;
      down_q <= down_d;
    end
  end
  assign key_code_o = code_q;
  assign key_valid_o = valid_q;
  assign key_down_o = down_q;
endmodule

// File: rtl/keypad_scan.sv
// keypad_scan: 4x4 keypad column scanner with row synchronizer, per-sweep encoder and debounce
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int CLK_DIV  = 100000,
  parameter int DEBOUNCE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);
  localparam int DW = $clog2(CLK_DIV);
  logic [3:0] sync1_q, sync2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [4:0] best_q, best_d, col_hit, prior, sweep_res;
  logic tick, sweep_end;
  assign tick = div_q == DW'(CLK_DIV - 1);
  assign sweep_end = tick && col_idx_q == 2'd3;
  assign div_d = tick ? '0 : div_q + 1'b1;
  assign col_idx_d = tick ? col_idx_q + 2'd1 : col_idx_q;
  assign col = COL_PATTERN[col_idx_q];
  // Lowest active row in this column; codes from earlier columns compete by plain min
  assign col_hit = !sync2_q[0] ? key_code_f(2'd0, col_idx_q) :
                   !sync2_q[1] ? key_code_f(2'd1, col_idx_q) :
                   !sync2_q[2] ? key_code_f(2'd2, col_idx_q) :
                   !sync2_q[3] ? key_code_f(2'd3, col_idx_q) : NO_KEY;
  assign prior = (col_idx_q == 2'd0) ? NO_KEY : best_q;
  assign sweep_res = (col_hit < prior) ? col_hit : prior;
  assign best_d = tick ? sweep_res : best_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 4'hF;
      sync2_q <= 4'hF;
      div_q <= '0;
      col_idx_q <= 2'd0;
      best_q <= NO_KEY;
    end else begin
      sync1_q <= row;
      sync2_q <= sync1_q;
      div_q <= div_d;
      col_idx_q <= col_idx_d;
      best_q <= best_d;
    end
  end
  keypad_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
    .clk(clk),
    .reset(reset),
    .sweep_i(sweep_end),
    .result_i(sweep_res),
    .key_code_o(key_code),
    .key_valid_o(key_valid),
    .key_down_o(key_down)
  );
endmodule

// File: tb/tb_keypad_scan.sv
// tb_keypad_scan: random and directed keypad presses checked cycle by cycle against a run-length model
module tb_keypad_scan;
  localparam int CLK_DIV = 4;
  localparam int DEBOUNCE = 2;
  localparam int SW = 4 * CLK_DIV;
  logic clk = 1'b0, reset = 1'b0;
  logic [3:0] row, col, key_code;
  logic key_valid, key_down;
  logic [15:0] mask = 16'h0;
  int checks = 0, failures = 0, cyc = 0, pulses = 0, valid_cyc = -1;
  bit started = 0;
  int m_last = 16, m_run = 0, m_code = 0;
  bit m_valid = 0, m_down = 0;
  logic [3:0] exp_col [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  keypad_scan #(.CLK_DIV(CLK_DIV), .DEBOUNCE(DEBOUNCE)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_code(key_code), .key_valid(key_valid), .key_down(key_down)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its row low while its column is driven low
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (mask[4*r+c] && !col[c]) row[r] = 1'b0;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lowest(input logic [15:0] m);
    for (int k = 0; k < 16; k++) if (m[k]) return k;
    return 16;
  endfunction

  initial begin
    int res;
    forever begin
      @(posedge clk);
      if (reset) begin
        started = 1; cyc = 0; m_last = 16; m_run = 0;
        m_code = 0; m_valid = 0; m_down = 0;
      end else if (started) begin
        m_valid = 0;
        if (cyc % SW == SW - 1) begin
          res = lowest(mask);
          if (res == m_last) m_run = (m_run < 1000) ? m_run + 1 : m_run;
          else begin m_last = res; m_run = 1; end
          if (!m_down && res != 16 && m_run == DEBOUNCE) begin
            m_down = 1; m_valid = 1; m_code = res;
          end else if (m_down && res == 16 && m_run == DEBOUNCE) m_down = 0;
        end
        cyc++;
      end
      #1;
      if (started) begin
        chk("col", col, exp_col[(cyc / CLK_DIV) % 4]);
        chk("key_valid", key_valid, m_valid);
        chk("key_down", key_down, m_down);
        chk("key_code", key_code, m_code);
        if (key_valid === 1'b1) begin pulses++; valid_cyc = cyc; end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic do_sweep(input logic [15:0] m);
    int n = 0;
    while (cyc % SW != 0 && n < 4 * SW) begin @(negedge clk); n++; end
    if (n >= 4 * SW) chk("sweep_align_timeout", cyc % SW, 0);
    mask = m;
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] nm;
    do_reset();
    pulses = 0;
    repeat (4) do_sweep(16'h0);
    chk("idle_pulses", pulses, 0);
    chk("idle_code", key_code, 0);
    chk("idle_down", key_down, 0);

    do_reset();
    pulses = 0;
    repeat (4) do_sweep(16'h0200);
    chk("press_pulses", pulses, 1);
    chk("press_valid_cyc", valid_cyc, 32);
    chk("press_code", key_code, 4'h9);
    chk("press_down", key_down, 1);
    repeat (2) do_sweep(16'h0008);
    repeat (2) do_sweep(16'h0);
    chk("rel_pend_down", key_down, 1);
    do_sweep(16'h0);
    chk("rollover_pulses", pulses, 1);
    chk("rollover_code", key_code, 4'h9);
    chk("release_down", key_down, 0);

    do_reset();
    pulses = 0;
    for (int i = 0; i < 6; i++) do_sweep((i % 2 == 0) ? 16'h0200 : 16'h0);
    do_sweep(16'h0);
    chk("bounce_pulses", pulses, 0);
    chk("bounce_down", key_down, 0);

    do_reset();
    pulses = 0;
    repeat (2) do_sweep(16'h0044);
    do_sweep(16'h0);
    chk("multi_pulses", pulses, 1);
    chk("multi_code", key_code, 4'h2);

    do_reset();
    repeat (2) do_sweep(16'h0200);
    repeat (4) @(negedge clk);
    chk("midpress_down", key_down, 0);
    do_reset();
    pulses = 0;
    chk("midpress_reset_code", key_code, 0);
    repeat (2) do_sweep(16'h0200);
    chk("midpress_early_pulses", pulses, 0);
    do_sweep(16'h0200);
    chk("midpress_pulses", pulses, 1);
    chk("midpress_valid_cyc", valid_cyc, 32);

    nm = 16'h0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: nm = nm;
        3, 4: nm = 16'h0;
        5, 6: nm = 16'h1 << $urandom_range(0, 15);
        default: nm = (16'h1 << $urandom_range(0, 15)) | (16'h1 << $urandom_range(0, 15));
      endcase
      do_sweep(nm);
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(0, 12)) @(negedge clk);
        do_reset();
      end
    end
    repeat (3) do_sweep(16'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
REQ-001 The block SHALL have parameter CLK_DIV, default 100000, giving the clk cycles each column is driven (dwell); legal values are 2 or more.
REQ-002 The block SHALL have parameter DEBOUNCE, default 3, giving the consecutive identical full sweeps required to accept a press or release; legal range is 1 to 15.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 Port clk  input  1  system clock, the single clock domain.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port row  input  4  keypad rows, active-low, externally pulled up, asynchronous to clk.
REQ-007 Port col  output  4  keypad column drive, active-low, exactly one column low at any time.
REQ-008 Port key_code  output  4  code of the last accepted key, 4*row_idx + col_idx, valid range 0x0 to 0xF.
REQ-009 Port key_valid  output  1  one-cycle pulse marking a newly accepted press.
REQ-010 Port key_down  output  1  level, high while an accepted key is held.

Function
REQ-011 The row input SHALL pass through a 2-flop synchronizer before any use.
REQ-012 Column scan sequence:
- col SHALL step 1110 -> 1101 -> 1011 -> 0111 -> 1110.
- col advances after CLK_DIV cycles of dwell and wraps with no gap.
- col_idx SHALL be 0..3 in that order.
REQ-013 Row sampling:
- The synchronized row SHALL be sampled on the last cycle of each dwell (tick).
- One sweep is 4 dwells, i.e. 4*CLK_DIV cycles.
REQ-014 Per-sweep result:
- At the col_idx=3 tick the block SHALL produce one result: the pressed key with the lowest code, or NO_KEY.
- When several keys are pressed, the lowest code SHALL win.
REQ-015 Debounce FSM states SHALL be IDLE, PRESS_PEND, HELD and REL_PEND; the FSM evaluates only at sweep ends.
REQ-016 IDLE:
- Key k -> PRESS_PEND, cand=k, cnt=1.
- If DEBOUNCE=1, go directly to HELD and accept k.
- NO_KEY -> stay in IDLE.
REQ-017 PRESS_PEND:
- Same k -> cnt+1; when cnt reaches DEBOUNCE -> HELD and accept k.
- A different key -> restart with cand=new key, cnt=1.
- NO_KEY -> IDLE.
REQ-018 Accepting a key SHALL, in the same clk cycle:
- load key_code=cand;
- pulse key_valid high for exactly one cycle;
- set key_down=1.
REQ-019 HELD:
- Any key, including a different one (rollover), -> stay in HELD; no new pulse and key_code unchanged.
- NO_KEY -> REL_PEND, cnt=1; if DEBOUNCE=1, go directly to IDLE.
REQ-020 REL_PEND:
- NO_KEY -> cnt+1; when cnt reaches DEBOUNCE -> IDLE and key_down=0.
- Any key -> back to HELD with no key_valid pulse.
REQ-021 key_code SHALL hold its value through release and idle until the next acceptance.
REQ-022 Latency: a key stable from a sweep start SHALL produce key_valid on the final tick of the DEBOUNCE-th complete sweep, plus 2 cycles of synchronizer delay already absorbed in the sampling.
REQ-023 Counters SHALL saturate and never wrap; the dwell counter SHALL wrap to 0 at CLK_DIV-1.

Reset
REQ-024 While reset is high at a clk edge, the block SHALL set:
- col=1110 and the dwell counter to 0;
- state=IDLE and cnt=0;
- key_code=0x0, key_valid=0, key_down=0;
- synchronizer flops to 1111.
REQ-025 Reset mid-dwell or mid-debounce SHALL discard partial results; scanning restarts at col_idx 0 on the first cycle after reset deasserts.

Structure
REQ-026 Package keypad_pkg SHALL hold:
- the FSM state enum;
- the COL_PATTERN constants;
- the NO_KEY encoding (5-bit value 0x10);
- the code function 4*row+col.
REQ-027 The debounce FSM SHALL be a sub-module keypad_debounce. Its inputs are the sweep-end strobe and the 5-bit sweep result; its outputs are key_code, key_valid and key_down.
REQ-028 keypad_scan SHALL contain only the synchronizer, the column scan counter, the row sampling and the per-sweep encoder, plus the keypad_debounce instance.

Verification (CLK_DIV=4, DEBOUNCE=2, sweep = 16 cycles)
REQ-029 Idle scan:
- Stimulus: reset for 3 cycles, then row=1111.
- Response: col cycles 1110, 1101, 1011, 0111, changing every 4 cycles; key_valid, key_down and key_code stay 0.
REQ-030 Single press:
- Stimulus: row=1011 only while col=1101 (row 2, col 1), held 3 sweeps.
- Response: exactly one key_valid pulse at the end of sweep 2 with key_code=0x9; key_down=1.
REQ-031 Bounce:
- Stimulus: press toggles on and off on alternate sweeps.
- Response: no key_valid pulse; key_down stays 0.
REQ-032 Release and rollover:
- Stimulus: hold 0x9, then switch to 0x3 without a gap, then release for 2 sweeps.
- Response: no second pulse; key_code stays 0x9; key_down falls at the end of the second empty sweep.
REQ-033 Multi-key:
- Stimulus: 0x6 and 0x2 held together for 2 sweeps.
- Response: one pulse with key_code=0x2.
REQ-034 Reset mid-press:
- Stimulus: assert reset during PRESS_PEND.
- Response: outputs return to reset values; the key still held produces a pulse only after 2 further full sweeps.
